change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Downstream of vending_machine: takes the change amount the machine owes after a vend or cancelReset, and drives the coin-ejector solenoids one coin at a time.
Change is made greedily from quarters, then dimes, then nickels, skipping any tube reported empty.
Each solenoid pulse has a fixed width followed by a mechanical recovery gap.
Reports busy, done and fault back to vending_machine; the remaining balance is available for the 7-segment display path.

Parameters:
PULSE_CYCLES, 50000000, clk cycles each ejector output stays high (0.5 s at 100 MHz); minimum 1
GAP_CYCLES, 25000000, clk cycles of idle between consecutive coins; minimum 1
MAX_NICKELS, 100, largest accepted request in nickel units ($5.00)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request strobe from vending_machine
amount  in  7  change owed, in nickel units (5 cents each)
quarterEmpty  in  1  quarter tube empty
dimeEmpty  in  1  dime tube empty
nickelEmpty  in  1  nickel tube empty
ejQuarter  out  1  quarter solenoid drive
ejDime  out  1  dime solenoid drive
ejNickel  out  1  nickel solenoid drive
busy  out  1  high from the cycle after start is accepted until the cycle after done or fault is set
done  out  1  one-cycle pulse: exact change fully paid
fault  out  1  sticky flag: change cannot be completed
remaining  out  7  nickel units still owed
coinsOut  out  7  coins ejected for the current request

Behaviour:
- Reset (async, active-high) values: all outputs 0; state IDLE; internal counters 0.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, SELECT, PULSE, GAP, DONE, FAULT.
- IDLE:
  - start=1 with amount<=MAX_NICKELS: load remaining=amount, clear coinsOut, clear fault, busy=1, go to SELECT next cycle.
  - start=1 with amount>MAX_NICKELS: remaining=amount, go to FAULT.
  - start=0: stay in IDLE.
- SELECT (exactly 1 cycle), priority order:
  - remaining==0: go to DONE.
  - remaining>=5 and !quarterEmpty: quarter.
  - else remaining>=2 and !dimeEmpty: dime.
  - else remaining>=1 and !nickelEmpty: nickel.
  - else: go to FAULT.
  - The empty flags are sampled only in SELECT.
- Entering PULSE, in the same clock edge: the chosen ej* output goes high; remaining decreases by 5, 2 or 1 for quarter, dime or nickel; coinsOut increments.
- PULSE: the ej* output stays high for exactly PULSE_CYCLES cycles, then GAP.
- GAP: all ej* low for exactly GAP_CYCLES cycles, then SELECT.
- At most one ej* output is high at any time.
- DONE: done=1 for one cycle, busy=0 on exit, go to IDLE.
- FAULT: fault=1, busy=0, go to IDLE next cycle.
  - fault stays high until the next accepted start or reset.
  - remaining holds the shortfall.
- Greedy is not backtracking. Example: remaining=3 with nickelEmpty gives a dime, then FAULT with remaining=1. This is required behaviour.
- start while busy (any state other than IDLE) is ignored; the amount is not latched.
- An empty flag asserted during PULSE or GAP does not affect the coin in flight.
- amount=0 with start: SELECT, then DONE. done pulses 2 cycles after start; no ejector fires.
- Reset mid-PULSE: the ejector drops immediately (async); the owed amount is lost.
- remaining never underflows, because each subtraction is guarded by its >= test in SELECT.

Decomposition:
- Shared header vending_defs.vh holds:
  - coin values in nickel units: NICKEL_VAL=1, DIME_VAL=2, QUARTER_VAL=5
  - state encodings
  - MAX_NICKELS
- One sub-module, dispense_timer: a loadable down-counter with load/value/expired, parameter WIDTH.
  - One instance is shared by PULSE and GAP; it is reloaded with PULSE_CYCLES or GAP_CYCLES on state entry.

Test Plan (bench overrides PULSE_CYCLES=2, GAP_CYCLES=1):
1. Start with amount=8, all tubes full -> ejector order quarter, dime, nickel.
   - Each ejector is high exactly 2 cycles with a 1-cycle gap between coins.
   - remaining steps 8, 3, 1, 0; coinsOut=3; done one cycle; fault=0.
2. Start with amount=0 -> done 2 cycles after start; no ej* pulse; coinsOut=0.
3. Start with amount=10, quarterEmpty=1 -> 5 dime pulses; done; coinsOut=5.
4. Start with amount=3, nickelEmpty=1 -> 1 dime, then fault=1, remaining=1, busy=0.
   - Follow with start amount=1, nickelEmpty=0 -> fault clears, 1 nickel, done.
5. Start with amount=101 -> fault=1 the next cycle, no ejection.
   - start pulses issued mid-dispense (with another amount) are ignored and remaining is unaffected.
6. Assert reset during the second cycle of a quarter pulse -> ejQuarter, busy and remaining are 0 immediately.
   - After reset release, a new start with amount=2 dispenses 1 dime and reaches done.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser.
//   - coin values expressed in nickel units
//   - request amount width and the default largest accepted request
//   - controller state encoding
package change_dispenser_pkg;

    localparam int AMT_W = 7;

    localparam logic [AMT_W-1:0] NICKEL_VAL  = 7'd1;
    localparam logic [AMT_W-1:0] DIME_VAL    = 7'd2;
    localparam logic [AMT_W-1:0] QUARTER_VAL = 7'd5;

    // $5.00 in nickels
    localparam int MAX_NICKELS_DEFAULT = 100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter used to time solenoid pulses and recovery gaps.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         load 'value' into the counter this cycle
//   value        reload value (a duration of N cycles is loaded as N-1)
//   expired      counter has reached zero
module dispense_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays a nickel-unit amount greedily from quarters,
// dimes and nickels (skipping empty tubes), one solenoid pulse at a time,
// each pulse followed by a mechanical recovery gap.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   start, amount                      request strobe and amount owed (nickels)
//   quarterEmpty/dimeEmpty/nickelEmpty tube empty flags (sampled in SELECT)
//   ejQuarter/ejDime/ejNickel          solenoid drives
//   busy, done, fault                  status back to the vending machine
//   remaining, coinsOut                balance still owed, coins paid so far
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 50000000,
    parameter int GAP_CYCLES   = 25000000,
    parameter int MAX_NICKELS  = MAX_NICKELS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             quarterEmpty,
    input  logic             dimeEmpty,
    input  logic             nickelEmpty,
    output logic             ejQuarter,
    output logic             ejDime,
    output logic             ejNickel,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] coinsOut
);

    // One timer covers both PULSE and GAP, so size it for the longer one.
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    // The timer is loaded on the entry edge and the state exits on the cycle
    // it reads zero, so an N-cycle interval loads N-1.
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    state_t           state, state_n;
    logic [AMT_W-1:0] remaining_n, coins_n;
    logic             ejq_n, ejd_n, ejn_n;
    logic             busy_n, done_n, fault_n;
    logic             tmr_load;
    logic [TW-1:0]    tmr_value;
    logic             tmr_expired;

    dispense_timer #(.WIDTH(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    // Every output is a flop; the combinational block computes their next
    // values together with the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            coinsOut  <= '0;
            ejQuarter <= 1'b0;
            ejDime    <= 1'b0;
            ejNickel  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            coinsOut  <= coins_n;
            ejQuarter <= ejq_n;
            ejDime    <= ejd_n;
            ejNickel  <= ejn_n;
            busy      <= busy_n;
            done      <= done_n;
            fault     <= fault_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        coins_n     = coinsOut;
        ejq_n       = ejQuarter;
        ejd_n       = ejDime;
        ejn_n       = ejNickel;
        busy_n      = busy;
        done_n      = 1'b0;
        fault_n     = fault;
        tmr_load    = 1'b0;
        tmr_value   = PULSE_LOAD;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    remaining_n = amount;
                    coins_n     = '0;
                    if (int'(amount) > MAX_NICKELS) begin
                        // Rejected outright: never becomes busy.
                        state_n = ST_FAULT;
                        fault_n = 1'b1;
                    end else begin
                        state_n = ST_SELECT;
                        fault_n = 1'b0;
                        busy_n  = 1'b1;
                    end
                end
            end

            ST_SELECT: begin
                // Greedy, no backtracking. Each >= guard also keeps the
                // subtraction below from underflowing.
                if (remaining == '0) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else if (remaining >= QUARTER_VAL && !quarterEmpty) begin
                    state_n     = ST_PULSE;
                    ejq_n       = 1'b1;
                    remaining_n = remaining - QUARTER_VAL;
                    coins_n     = coinsOut + 7'd1;
                    tmr_load    = 1'b1;
                end else if (remaining >= DIME_VAL && !dimeEmpty) begin
                    state_n     = ST_PULSE;
                    ejd_n       = 1'b1;
                    remaining_n = remaining - DIME_VAL;
                    coins_n     = coinsOut + 7'd1;
                    tmr_load    = 1'b1;
                end else if (remaining >= NICKEL_VAL && !nickelEmpty) begin
                    state_n     = ST_PULSE;
                    ejn_n       = 1'b1;
                    remaining_n = remaining - NICKEL_VAL;
                    coins_n     = coinsOut + 7'd1;
                    tmr_load    = 1'b1;
                end else begin
                    // remaining keeps the shortfall
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                end
            end

            ST_PULSE: begin
                if (tmr_expired) begin
                    state_n   = ST_GAP;
                    ejq_n     = 1'b0;
                    ejd_n     = 1'b0;
                    ejn_n     = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LOAD;
                end
            end

            ST_GAP: begin
                if (tmr_expired) begin
                    state_n = ST_SELECT;
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end

            ST_FAULT: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser. For each request a reference model
// first works out the coin list from the greedy rule (using the empty flags
// that will be presented at each selection), then the expected value of every
// output is derived per cycle from that list and the pulse/gap timing.
module tb_change_dispenser;

    localparam int P    = 2;
    localparam int G    = 1;
    localparam int K    = P + G + 1;   // cycles per coin: select + pulse + gap
    localparam int MAXN = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] amount;
    logic       quarterEmpty, dimeEmpty, nickelEmpty;
    logic       ejQuarter, ejDime, ejNickel;
    logic       busy, done, fault;
    logic [6:0] remaining, coinsOut;

    change_dispenser #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .MAX_NICKELS  (MAXN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .amount       (amount),
        .quarterEmpty (quarterEmpty),
        .dimeEmpty    (dimeEmpty),
        .nickelEmpty  (nickelEmpty),
        .ejQuarter    (ejQuarter),
        .ejDime       (ejDime),
        .ejNickel     (ejNickel),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .remaining    (remaining),
        .coinsOut     (coinsOut)
    );

    always #5 clk = ~clk;

    logic [19:0] vec;
    assign vec = {ejQuarter, ejDime, ejNickel, busy, done, fault, remaining, coinsOut};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2:0] m_flags [0:128];   // {quarterEmpty, dimeEmpty, nickelEmpty} per selection
    int         m_val   [0:127];   // coin values (nickels) in eject order
    int         m_amt, m_n, m_end;
    bit         m_acc, m_fault;

    task automatic build_model(input int a);
        int rem;
        int c;
        m_amt = a;
        m_n   = 0;
        if (a > MAXN) begin
            m_acc   = 0;
            m_fault = 1;
            m_end   = 1;
            return;
        end
        m_acc = 1;
        rem   = a;
        forever begin
            if (rem == 0) begin
                m_fault = 0;
                break;
            end
            c = 0;
            if (rem >= 5 && !m_flags[m_n][2])      c = 5;
            else if (rem >= 2 && !m_flags[m_n][1]) c = 2;
            else if (rem >= 1 && !m_flags[m_n][0]) c = 1;
            if (c == 0) begin
                m_fault = 1;
                break;
            end
            m_val[m_n] = c;
            rem -= c;
            m_n++;
        end
        m_end = 2 + m_n * K;
    endtask

    // Expected outputs t cycles after the start cycle.
    function automatic logic [19:0] exp_at(input int t);
        int rem = m_amt;
        int cnt = 0;
        logic q = 0, d = 0, n = 0;
        logic b, dn, f;
        for (int i = 0; i < m_n; i++) begin
            int ps = 2 + i * K;
            if (t >= ps) begin
                rem -= m_val[i];
                cnt++;
                if (t < ps + P) begin
                    if (m_val[i] == 5) q = 1;
                    else if (m_val[i] == 2) d = 1;
                    else n = 1;
                end
            end
        end
        b  = m_acc && (t <= m_end);
        dn = m_acc && !m_fault && (t == m_end);
        f  = m_fault && (t >= m_end);
        return {q, d, n, b, dn, f, 7'(rem), 7'(cnt)};
    endfunction

    task automatic fill_flags(input logic [2:0] f);
        for (int i = 0; i <= 128; i++) m_flags[i] = f;
    endtask

    task automatic rand_flags();
        for (int i = 0; i <= 128; i++)
            m_flags[i] = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 7) == 0)};
    endtask

    // Called just after a negedge with the DUT idle. Optionally throws stray
    // start pulses (with random amounts) at the DUT while it is not idle.
    task automatic run_req(input int a, input bit junk);
        build_model(a);
        start  = 1'b1;
        amount = 7'(a);
        {quarterEmpty, dimeEmpty, nickelEmpty} = m_flags[0];
        for (int t = 1; t <= m_end + 1; t++) begin
            @(negedge clk);
            chk($sformatf("req%0d_t%0d", a, t), 32'(vec), 32'(exp_at(t)));
            start = 1'b0;
            if (junk && t <= m_end && $urandom_range(0, 4) == 0) begin
                start  = 1'b1;
                amount = 7'($urandom_range(0, 127));
            end
            // New flags arrive while a coin is in flight; they only count at
            // the next selection.
            for (int i = 0; i < m_n; i++)
                if (t == 2 + i * K) {quarterEmpty, dimeEmpty, nickelEmpty} = m_flags[i + 1];
        end
        start = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        amount = '0;
        {quarterEmpty, dimeEmpty, nickelEmpty} = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(vec), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 32'(vec), 32'd0);

        // Directed cases
        fill_flags(3'b000); run_req(8, 0);     // quarter, dime, nickel
        fill_flags(3'b000); run_req(0, 0);     // immediate done
        fill_flags(3'b100); run_req(10, 0);    // five dimes
        fill_flags(3'b001); run_req(3, 0);     // dime then fault, shortfall 1
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_rem", 32'(remaining), 32'd1);
        fill_flags(3'b000); run_req(1, 0);     // fault clears, one nickel
        fill_flags(3'b000); run_req(101, 0);   // rejected
        fill_flags(3'b000); run_req(13, 1);    // stray starts ignored
        fill_flags(3'b000); run_req(MAXN, 0);  // largest accepted request

        // Reset during the second cycle of a quarter pulse
        start  = 1'b1;
        amount = 7'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ejq", 32'(ejQuarter), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_ejq", 32'(ejQuarter), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rem", 32'(remaining), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fill_flags(3'b000); run_req(2, 0);

        // Random requests
        for (int r = 0; r < 40; r++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 127) : $urandom_range(0, 30);
            rand_flags();
            run_req(a, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
